// File: rtl/multicycle_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_fsm
//
// Multi-cycle control sequencer for an RV32I datapath. Each instruction steps
// through FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH. The sequencer
// drives the per-cycle datapath strobes and owns the shared single-port
// memory handshake used by both instruction fetch and data access.
//
// Ports
//   clk        in   1      system clock, rising edge
//   rst_n      in   1      asynchronous active-low reset
//   op         in   5      IR[6:2] opcode, valid from DECODE onward
//   mem_ready  in   1      memory completes the current request this cycle
//   mem_req    out  1      memory request, held until mem_ready
//   mem_iord   out  1      0 = PC address (fetch), 1 = ALU address (data)
//   mem_read   out  1      read strobe (fetch or load)
//   mem_write  out  1      store strobe
//   ir_write   out  1      latch fetched word into IR
//   pc_write   out  1      load PC with PC+4
//   branch     out  1      conditional PC update from branch target
//   alu_src    out  1      0 = rs2, 1 = immediate
//   alu_op     out  2      00 add, 01 branch compare, 10 R funct, 11 I funct
//   reg_write  out  1      register-file write enable
//   mem_to_reg out  1      writeback select: 1 = memory data, 0 = ALU
//   halted     out  1      SYSTEM opcode executed (sticky until reset)
//   trap       out  1      illegal opcode or memory timeout (sticky)
//   retired    out  CNT_W  instructions completed, wraps
// ---------------------------------------------------------------------------
module multicycle_ctrl_fsm #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       op,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic             branch,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             halted,
  output logic             trap,
  output logic [CNT_W-1:0] retired
);

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_ARITHI = 5'b00100;
  localparam logic [4:0] OP_ARITHR = 5'b01100;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic [4:0]       op_q, op_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [7:0]       wait_inc;

  assign wait_inc = wait_q + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      wait_q    <= 8'd0;
      op_q      <= 5'd0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      op_q      <= op_d;
      retired_q <= retired_d;
    end
  end

  // Next-state, wait counter, opcode latch and retire counter.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    op_d      = op_q;
    retired_d = retired_q;

    case (state_q)
      S_FETCH: begin
        if (mem_ready)               state_d = S_DECODE;
        else if (wait_inc == TIMEOUT_C) state_d = S_TRAP;
        else                         wait_d  = wait_inc;
      end
      S_DECODE: begin
        op_d = op;
        case (op)
          OP_SYSTEM:                                  state_d = S_HALT;
          OP_LOAD, OP_STORE, OP_ARITHI, OP_ARITHR,
          OP_BRANCH:                                  state_d = S_EXEC;
          default:                                    state_d = S_TRAP;
        endcase
      end
      S_EXEC: begin
        case (op_q)
          OP_ARITHR, OP_ARITHI: state_d = S_WB;
          OP_LOAD, OP_STORE:    state_d = S_MEM;
          OP_BRANCH:            state_d = S_FETCH;
          default:              state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        // A ready on the cycle the count would expire still completes.
        if (mem_ready)                  state_d = (op_q == OP_LOAD) ? S_WB : S_FETCH;
        else if (wait_inc == TIMEOUT_C) state_d = S_TRAP;
        else                            wait_d  = wait_inc;
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase

    // Fresh timeout window for every memory access.
    if ((state_d == S_FETCH || state_d == S_MEM) && state_d != state_q) begin
      wait_d = 8'd0;
    end

    if (state_d == S_FETCH &&
        (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB)) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  // Moore strobes. They are gated with rst_n so an asserted reset forces them
  // low immediately even though the reset state itself is FETCH.
  always_comb begin
    mem_req    = 1'b0;
    mem_iord   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    alu_src    = 1'b0;
    alu_op     = 2'b00;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    halted     = 1'b0;
    trap       = 1'b0;

    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem_req  = 1'b1;
          mem_read = 1'b1;
          // IR/PC update on the completing cycle is the one ready-dependent output.
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        S_EXEC: begin
          case (op_q)
            OP_ARITHR: begin alu_src = 1'b0; alu_op = 2'b10; end
            OP_ARITHI: begin alu_src = 1'b1; alu_op = 2'b11; end
            OP_LOAD, OP_STORE: begin alu_src = 1'b1; alu_op = 2'b00; end
            OP_BRANCH: begin alu_src = 1'b0; alu_op = 2'b01; branch = 1'b1; end
            default: ;
          endcase
        end
        S_MEM: begin
          mem_req   = 1'b1;
          mem_iord  = 1'b1;
          alu_src   = 1'b1;
          alu_op    = 2'b00;
          mem_read  = (op_q == OP_LOAD);
          mem_write = (op_q == OP_STORE);
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (op_q == OP_LOAD);
        end
        S_HALT:  halted = 1'b1;
        S_TRAP:  trap   = 1'b1;
        default: ;
      endcase
    end
  end

  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
module tb_multicycle_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  op;
  logic        mem_ready;
  logic        mem_req, mem_iord, mem_read, mem_write, ir_write, pc_write;
  logic        branch, alu_src, reg_write, mem_to_reg, halted, trap;
  logic [1:0]  alu_op;
  logic [31:0] retired;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_ret;

  multicycle_ctrl_fsm #(.TIMEOUT(255), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_iord(mem_iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .pc_write(pc_write),
    .branch(branch), .alu_src(alu_src), .alu_op(alu_op),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .halted(halted),
    .trap(trap), .retired(retired)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic nxt();
    @(posedge clk); #1;
  endtask

  // Leaves the DUT in its first FETCH cycle (released at a falling edge).
  task automatic do_reset();
    rst_n = 1'b0; mem_ready = 1'b0; op = 5'b11111;
    nxt(); nxt();
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; op = 5'b01100;
    nxt(); nxt();
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req got=%0b want=0", mem_req); end
    total++; if (ir_write !== 1'b0 || pc_write !== 1'b0 || mem_read !== 1'b0) begin bad++; $display("FAIL rst_strobes got=%0b%0b%0b want=000", ir_write, pc_write, mem_read); end
    total++; if (retired !== 32'd0) begin bad++; $display("FAIL rst_retired got=%0d want=0", retired); end
    total++; if (halted !== 1'b0 || trap !== 1'b0) begin bad++; $display("FAIL rst_flags got=%0b%0b want=00", halted, trap); end
  endtask

  task automatic test_arith_r();
    do_reset(); exp_ret = 0;
    mem_ready = 1'b1; #1;
    total++; if ({mem_req, mem_read, mem_iord, ir_write, pc_write} !== 5'b11011) begin bad++; $display("FAIL r_fetch got=%b want=11011", {mem_req, mem_read, mem_iord, ir_write, pc_write}); end
    nxt();
    mem_ready = 1'b0; op = 5'b01100; #1;
    total++; if (mem_req !== 1'b0 || reg_write !== 1'b0) begin bad++; $display("FAIL r_decode got=%0b%0b want=00", mem_req, reg_write); end
    nxt();
    op = 5'b11111; #1;
    total++; if ({alu_src, alu_op, reg_write} !== 4'b0100) begin bad++; $display("FAIL r_exec got=%b want=0100", {alu_src, alu_op, reg_write}); end
    nxt(); #1;
    total++; if ({reg_write, mem_to_reg} !== 2'b10 || retired !== 32'd0) begin bad++; $display("FAIL r_wb got=%b ret=%0d want=10 ret=0", {reg_write, mem_to_reg}, retired); end
    nxt(); #1;
    exp_ret = 1;
    total++; if (reg_write !== 1'b0 || mem_req !== 1'b1 || retired !== exp_ret) begin bad++; $display("FAIL r_retire got rw=%0b req=%0b ret=%0d want rw=0 req=1 ret=%0d", reg_write, mem_req, retired, exp_ret); end
  endtask

  task automatic test_load();
    int cyc = 0;
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i == 2); #1;
      total++; if (mem_req !== 1'b1 || mem_iord !== 1'b0 || ir_write !== (i == 2)) begin bad++; $display("FAIL ld_fetch%0d got req=%0b iord=%0b irw=%0b", i, mem_req, mem_iord, ir_write); end
      nxt(); cyc++;
    end
    mem_ready = 1'b0; op = 5'b00000; #1; nxt(); cyc++;
    op = 5'b01100; #1;
    total++; if ({alu_src, alu_op} !== 3'b100) begin bad++; $display("FAIL ld_exec got=%b want=100", {alu_src, alu_op}); end
    nxt(); cyc++;
    for (int i = 0; i < 2; i++) begin
      mem_ready = (i == 1); #1;
      total++; if ({mem_req, mem_iord, mem_read, mem_write, reg_write} !== 5'b11100) begin bad++; $display("FAIL ld_mem%0d got=%b want=11100", i, {mem_req, mem_iord, mem_read, mem_write, reg_write}); end
      nxt(); cyc++;
    end
    mem_ready = 1'b0; #1;
    total++; if ({reg_write, mem_to_reg} !== 2'b11 || retired !== exp_ret) begin bad++; $display("FAIL ld_wb got=%b ret=%0d want=11 ret=%0d", {reg_write, mem_to_reg}, retired, exp_ret); end
    nxt(); cyc++;
    exp_ret++;
    total++; if (retired !== exp_ret || mem_req !== 1'b1 || cyc != 8) begin bad++; $display("FAIL ld_retire got ret=%0d req=%0b cyc=%0d want ret=%0d req=1 cyc=8", retired, mem_req, cyc, exp_ret); end
  endtask

  task automatic test_store();
    logic rw_seen = 1'b0;
    logic wr_outside = 1'b0;
    mem_ready = 1'b1; #1;
    rw_seen |= reg_write; wr_outside |= mem_write; nxt();
    mem_ready = 1'b0; op = 5'b01000; #1;
    rw_seen |= reg_write; wr_outside |= mem_write; nxt();
    #1;
    rw_seen |= reg_write; wr_outside |= mem_write;
    total++; if ({alu_src, alu_op} !== 3'b100) begin bad++; $display("FAIL st_exec got=%b want=100", {alu_src, alu_op}); end
    nxt();
    mem_ready = 1'b1; #1;
    rw_seen |= reg_write;
    total++; if ({mem_req, mem_iord, mem_read, mem_write} !== 4'b1101) begin bad++; $display("FAIL st_mem got=%b want=1101", {mem_req, mem_iord, mem_read, mem_write}); end
    nxt();
    mem_ready = 1'b0; #1;
    rw_seen |= reg_write; wr_outside |= mem_write;
    exp_ret++;
    total++; if (retired !== exp_ret || mem_iord !== 1'b0 || mem_read !== 1'b1) begin bad++; $display("FAIL st_retire got ret=%0d iord=%0b rd=%0b want ret=%0d iord=0 rd=1", retired, mem_iord, mem_read, exp_ret); end
    total++; if (rw_seen !== 1'b0 || wr_outside !== 1'b0) begin bad++; $display("FAIL st_strobes got rw=%0b wr_out=%0b want 0 0", rw_seen, wr_outside); end
  endtask

  task automatic test_branch();
    mem_ready = 1'b1; #1; nxt();
    mem_ready = 1'b0; op = 5'b11000; #1; nxt();
    #1;
    total++; if ({branch, alu_src, alu_op, reg_write} !== 5'b10010) begin bad++; $display("FAIL br_exec got=%b want=10010", {branch, alu_src, alu_op, reg_write}); end
    nxt(); #1;
    exp_ret++;
    total++; if (retired !== exp_ret || branch !== 1'b0 || mem_req !== 1'b1) begin bad++; $display("FAIL br_retire got ret=%0d br=%0b req=%0b want ret=%0d br=0 req=1", retired, branch, mem_req, exp_ret); end
  endtask

  task automatic test_illegal_system();
    logic req_seen = 1'b0;
    logic trap_lost = 1'b0;
    do_reset();
    mem_ready = 1'b1; #1; nxt();
    mem_ready = 1'b0; op = 5'b11111; #1; nxt();
    #1;
    total++; if (trap !== 1'b1 || mem_req !== 1'b0 || halted !== 1'b0) begin bad++; $display("FAIL ill_trap got trap=%0b req=%0b halt=%0b want 1 0 0", trap, mem_req, halted); end
    for (int i = 0; i < 6; i++) begin
      mem_ready = i[0]; #1;
      req_seen |= mem_req; trap_lost |= ~trap;
      nxt();
    end
    total++; if (req_seen !== 1'b0 || trap_lost !== 1'b0) begin bad++; $display("FAIL ill_sticky got req_seen=%0b trap_lost=%0b want 0 0", req_seen, trap_lost); end
    do_reset();
    mem_ready = 1'b1; #1; nxt();
    mem_ready = 1'b0; op = 5'b11100; #1; nxt();
    repeat (3) nxt();
    mem_ready = 1'b1; #1;
    total++; if (halted !== 1'b1 || trap !== 1'b0 || mem_req !== 1'b0 || retired !== 32'd0) begin bad++; $display("FAIL sys_halt got halt=%0b trap=%0b req=%0b ret=%0d want 1 0 0 0", halted, trap, mem_req, retired); end
  endtask

  task automatic test_timeout();
    do_reset();
    mem_ready = 1'b0;
    repeat (254) nxt();
    #1;
    total++; if (trap !== 1'b0 || mem_req !== 1'b1) begin bad++; $display("FAIL to_cycle255 got trap=%0b req=%0b want 0 1", trap, mem_req); end
    nxt(); #1;
    total++; if (trap !== 1'b1 || mem_req !== 1'b0) begin bad++; $display("FAIL to_trap got trap=%0b req=%0b want 1 0", trap, mem_req); end
    do_reset();
    mem_ready = 1'b0;
    repeat (254) nxt();
    mem_ready = 1'b1; #1;
    total++; if (ir_write !== 1'b1 || trap !== 1'b0) begin bad++; $display("FAIL to_ready_win got irw=%0b trap=%0b want 1 0", ir_write, trap); end
    nxt();
    mem_ready = 1'b0; op = 5'b01100; #1;
    total++; if (trap !== 1'b0 || mem_req !== 1'b0) begin bad++; $display("FAIL to_no_trap got trap=%0b req=%0b want 0 0", trap, mem_req); end
    nxt(); nxt(); nxt(); #1;
    total++; if (retired !== 32'd1 || trap !== 1'b0) begin bad++; $display("FAIL to_after_ret got ret=%0d trap=%0b want 1 0", retired, trap); end
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    mem_ready = 1'b1; #1; nxt();
    mem_ready = 1'b0; op = 5'b00000; #1; nxt();
    nxt(); #1;
    total++; if (mem_req !== 1'b1 || mem_iord !== 1'b1) begin bad++; $display("FAIL mr_in_mem got req=%0b iord=%0b want 1 1", mem_req, mem_iord); end
    rst_n = 1'b0; #1;
    total++; if (mem_req !== 1'b0 || mem_read !== 1'b0 || mem_iord !== 1'b0) begin bad++; $display("FAIL mr_drop got req=%0b rd=%0b iord=%0b want 0 0 0", mem_req, mem_read, mem_iord); end
    @(negedge clk); rst_n = 1'b1; #1;
    total++; if (mem_req !== 1'b1 || mem_iord !== 1'b0 || retired !== 32'd0 || trap !== 1'b0) begin bad++; $display("FAIL mr_release got req=%0b iord=%0b ret=%0d trap=%0b want 1 0 0 0", mem_req, mem_iord, retired, trap); end
  endtask

  initial begin
    rst_n = 1'b0; op = 5'd0; mem_ready = 1'b0; exp_ret = 0;
    test_reset();
    test_arith_r();
    test_load();
    test_store();
    test_branch();
    test_illegal_system();
    test_timeout();
    test_reset_mid_mem();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
